// File: rtl/memory_ram.sv
// Word-addressed register-file RAM: combinational read, rising-edge write,
// asynchronous active-low clear of every word.
module memory_ram #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [31:0]       A,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [ADDR_BITS-1:0] word_idx;
    logic [DATA_W-1:0]    mem [0:DEPTH-1];

    // Upper address bits alias the array and are deliberately dropped.
    logic unused_addr_bits;

    assign word_idx         = A[ADDR_BITS-1:0];
    assign unused_addr_bits = ^A[31:ADDR_BITS];

    // Flops rather than block RAM: every word must clear asynchronously and
    // the read path is purely combinational.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;
            logic              hit;

            assign hit = we && (word_idx == ADDR_BITS'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (hit) begin
                    word_reg <= WD;
                end
            end

            assign mem[gi] = word_reg;
        end
    endgenerate

    assign RD = mem[word_idx];

endmodule

// File: tb/tb_memory_ram.sv
// Directed self-checking bench for memory_ram (8 x 32-bit, word addressed).
module tb_memory_ram;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    int checks;
    int errors;
    logic [31:0] model [0:7];

    memory_ram #(.ADDR_BITS(3), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .A     (A),
        .WD    (WD),
        .RD    (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One write: inputs set at the falling edge, committed at the next rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        A  = addr;
        WD = data;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] expv, input string tag);
        we = 1'b0;
        A  = addr;
        #1;
        check(tag, RD, expv);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        we     = 1'b0;
        A      = 32'd0;
        WD     = 32'd0;

        // Reset then read
        #2 rst_n = 1'b0;
        #1 check("rd_during_reset", RD, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd(i, 32'h0, $sformatf("reset_rd[%0d]", i));

        // Fill every word with the same value
        for (int i = 0; i < 8; i++) wr(i, 32'h0000F001);
        for (int i = 0; i < 8; i++) rd(i, 32'h0000F001, $sformatf("fill_rd[%0d]", i));

        // Distinct data per word
        for (int i = 0; i < 8; i++) begin
            wr(i, 32'h100 + i);
            model[i] = 32'h100 + i;
        end
        for (int i = 0; i < 8; i++) rd(i, model[i], $sformatf("distinct_rd[%0d]", i));

        // A and WD wander mid-cycle with we high: only the edge-time pair is written
        @(negedge clk);
        we = 1'b1;
        A  = 32'd1; WD = 32'hAAAA0001;
        #1 A = 32'd4; WD = 32'hAAAA0004;
        #1 A = 32'd6; WD = 32'h00000055;
        @(posedge clk);
        #1 we = 1'b0;
        model[6] = 32'h00000055;
        rd(1, model[1], "midcycle_a1");
        rd(4, model[4], "midcycle_a4");
        rd(6, model[6], "midcycle_a6");

        // Single overwrite leaves the other seven words intact
        wr(3, 32'hDEADBEEF);
        model[3] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) rd(i, model[i], $sformatf("overwrite_rd[%0d]", i));

        // we low for three edges with junk data on the bus
        @(negedge clk);
        we = 1'b0; A = 32'd2; WD = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1 check("we_low_word2", RD, model[2]);

        // Address aliasing: 0xA maps to word 2
        wr(32'h0000000A, 32'hA5A5A5A5);
        model[2] = 32'hA5A5A5A5;
        rd(2, 32'hA5A5A5A5, "alias_rd2");
        rd(32'hFFFFFFF2, 32'hA5A5A5A5, "alias_rd_hi");

        // Asynchronous reset in the middle of a pending write
        @(negedge clk);
        A = 32'd7; WD = 32'h12345678; we = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_clear_a7", RD, 32'h0);
        A = 32'd3;
        #1 check("async_clear_a3", RD, 32'h0);
        A = 32'd7;
        @(posedge clk);
        #1 check("reset_blocks_write", RD, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_release_pre_edge", RD, 32'h0);
        @(posedge clk);
        #1 check("first_write_after_reset", RD, 32'h12345678);
        we = 1'b0;
        rd(2, 32'h0, "other_word_cleared");

        // Read during write at the same address
        wr(5, 32'h11111111);
        @(negedge clk);
        A = 32'd5; WD = 32'h22222222; we = 1'b1;
        #1 check("rdw_before_edge", RD, 32'h11111111);
        @(posedge clk);
        #1 check("rdw_after_edge", RD, 32'h22222222);
        we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
